// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD SPI bit engine: state encoding,
// SCK half-period table, frame constants and a serial CRC7 step.
package sd_spi_pkg;

    typedef enum logic [2:0] {IDLE, DUMMY, CMD, POLL, RESP, GAP, DONE} spi_state_e;

    localparam int         CMD_BITS   = 48;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;
    localparam logic [6:0] CRC7_POLY  = 7'h09;
    localparam int         HALF_TABLE [4] = '{128, 32, 4, 1};

    // Out-of-range response lengths are clamped to the legal 1..6 bytes.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        if (len == 3'd0) return 3'd1;
        if (len == 3'd7) return 3'd6;
        return len;
    endfunction

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        return {crc[5:0], 1'b0} ^ ((b ^ crc[6]) ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// SCK generator: free-running half-period counter while enabled, with
// single-cycle strobes on the cycle before SCK rises or falls.
module sd_spi_clkgen (
    input  logic       control_clk_i,
    input  logic       control_rst_i,
    input  logic       spi_rst_i,
    input  logic       en,
    input  logic [7:0] half,
    output logic       sck,
    output logic       rise,
    output logic       fall
);
    logic [7:0] cnt;
    logic       wrap;

    assign wrap = en && (cnt == half - 8'd1);
    assign rise = wrap && !sck;
    assign fall = wrap && sck;

    always_ff @(posedge control_clk_i or posedge control_rst_i) begin
        if (control_rst_i) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (spi_rst_i || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sd_spi_master.sv
// SD SPI mode-0 master: sends a 48-bit command, polls for the response token
// and collects up to 6 response bytes. Define SD_SPI_CRC7_EN to send a CRC7.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int NCR_MAX    = 8,
    parameter int DUMMY_CLKS = 80,
    parameter int HALF_DIV0  = HALF_TABLE[0],
    parameter int HALF_DIV1  = HALF_TABLE[1],
    parameter int HALF_DIV2  = HALF_TABLE[2],
    parameter int HALF_DIV3  = HALF_TABLE[3]
) (
    input  logic        control_clk_i,
    input  logic        control_rst_i,
    input  logic        spi_rst_i,
    input  logic        spi_start_i,
    input  logic        spi_fbo_i,
    input  logic [47:0] instruction_i,
    input  logic [1:0]  clock_divider_i,
    input  logic [2:0]  resp_len_i,
    output logic [47:0] spi_data_o,
    output logic        spi_done_o,
    output logic        spi_busy_o,
    output logic        spi_timeout_o,
    output logic        sd_sck_o,
    output logic        sd_mosi_o,
    output logic        sd_cs_n_o,
    input  logic        sd_miso_i
);
    spi_state_e  state, state_d;
    logic [47:0] tx_q, tx_nxt, rx_q;
    logic [6:0]  bit_cnt, resp_last;
    logic [2:0]  len_q;
    logic [1:0]  div_q;
    logic [7:0]  half;
    logic        sck_en, rise, fall, byte_end;
`ifdef SD_SPI_CRC7_EN
    logic [6:0]  crc_q;
`endif

    always_comb begin
        case (div_q)
            2'd0:    half = 8'(HALF_DIV0);
            2'd1:    half = 8'(HALF_DIV1);
            2'd2:    half = 8'(HALF_DIV2);
            default: half = 8'(HALF_DIV3);
        endcase
    end

    // SCK is parked low in DONE so the last falling edge is the final one.
    assign sck_en     = (state != IDLE) && (state != DONE);
    assign spi_busy_o = (state != IDLE);
    assign byte_end   = fall && (bit_cnt[2:0] == 3'd7);
    assign resp_last  = {1'b0, len_q - 3'd2, 3'b111};

    sd_spi_clkgen u_clkgen (
        .control_clk_i (control_clk_i),
        .control_rst_i (control_rst_i),
        .spi_rst_i     (spi_rst_i),
        .en            (sck_en),
        .half          (half),
        .sck           (sd_sck_o),
        .rise          (rise),
        .fall          (fall)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (spi_start_i) state_d = spi_fbo_i ? DUMMY : CMD;
            DUMMY:   if (fall && bit_cnt == 7'(DUMMY_CLKS - 1)) state_d = DONE;
            CMD:     if (fall && bit_cnt == 7'(CMD_BITS - 1)) state_d = POLL;
            POLL: begin
                if (byte_end) begin
                    if (!rx_q[7])                              state_d = (len_q == 3'd1) ? GAP : RESP;
                    else if (bit_cnt == 7'(NCR_MAX * 8 - 1))   state_d = GAP;
                end
            end
            RESP:    if (fall && bit_cnt == resp_last) state_d = GAP;
            GAP:     if (fall && bit_cnt == 7'd7) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // After bit 8 leaves the wire, the next byte becomes {crc, 1} when enabled.
    always_comb begin
        tx_nxt = {tx_q[46:0], 1'b0};
`ifdef SD_SPI_CRC7_EN
        if (bit_cnt == 7'(CMD_BITS - 9)) tx_nxt[47:40] = {crc7_step(crc_q, tx_q[47]), 1'b1};
`endif
    end

    always_ff @(posedge control_clk_i or posedge control_rst_i) begin
        if (control_rst_i)  state <= IDLE;
        else if (spi_rst_i) state <= IDLE;
        else                state <= state_d;
    end

    always_ff @(posedge control_clk_i or posedge control_rst_i) begin
        if (control_rst_i) begin
            tx_q <= '0; rx_q <= '0; bit_cnt <= '0; len_q <= 3'd1; div_q <= '0;
            sd_mosi_o <= 1'b1; sd_cs_n_o <= 1'b1; spi_done_o <= 1'b0;
            spi_timeout_o <= 1'b0; spi_data_o <= '0;
`ifdef SD_SPI_CRC7_EN
            crc_q <= '0;
`endif
        end else if (spi_rst_i) begin
            bit_cnt <= '0; div_q <= '0;
            sd_mosi_o <= 1'b1; sd_cs_n_o <= 1'b1; spi_done_o <= 1'b0;
            spi_timeout_o <= 1'b0; spi_data_o <= '0;
        end else begin
            spi_done_o <= (state == DONE);
            if (state_d != state) bit_cnt <= '0;
            else if (fall)        bit_cnt <= bit_cnt + 7'd1;
            if (rise) rx_q <= {rx_q[46:0], sd_miso_i};
            case (state)
                IDLE: if (spi_start_i) begin
                    tx_q          <= instruction_i;
                    div_q         <= clock_divider_i;
                    len_q         <= norm_len(resp_len_i);
                    spi_timeout_o <= 1'b0;
`ifdef SD_SPI_CRC7_EN
                    crc_q         <= '0;
`endif
                    if (!spi_fbo_i) begin
                        sd_cs_n_o <= 1'b0;
                        sd_mosi_o <= instruction_i[47];
                    end
                end
                CMD: if (fall) begin
                    tx_q      <= tx_nxt;
                    sd_mosi_o <= (state_d == POLL) ? FILL_BYTE[7] : tx_nxt[47];
`ifdef SD_SPI_CRC7_EN
                    if (bit_cnt < 7'(CMD_BITS - 8)) crc_q <= crc7_step(crc_q, tx_q[47]);
`endif
                end
                POLL: if (byte_end) begin
                    if (!rx_q[7]) begin
                        rx_q <= {40'd0, rx_q[7:0]};
                        if (len_q == 3'd1) spi_data_o <= {40'd0, rx_q[7:0]};
                    end else if (state_d == GAP) begin
                        spi_data_o    <= '1;
                        spi_timeout_o <= 1'b1;
                    end
                end
                RESP: if (fall && state_d == GAP) spi_data_o <= rx_q;
                GAP:  if (fall && state_d == DONE) sd_cs_n_o <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: a card model answers on MISO, a reference
// model predicts each completion, and a monitor checks every done pulse.
`timescale 1ns/1ps
module tb_sd_spi_master;
    localparam int NCR = 8;
    localparam int LAT_R1 = 2 * (48 + 8 + 8) + 3;

    logic        control_clk_i = 1'b0, control_rst_i = 1'b1, spi_rst_i = 1'b0;
    logic        spi_start_i = 1'b0, spi_fbo_i = 1'b0;
    logic [47:0] instruction_i = '0;
    logic [1:0]  clock_divider_i = '0;
    logic [2:0]  resp_len_i = 3'd1;
    logic [47:0] spi_data_o;
    logic        spi_done_o, spi_busy_o, spi_timeout_o, sd_sck_o, sd_mosi_o, sd_cs_n_o;
    logic        sd_miso_i = 1'b1;

    always #5 control_clk_i = ~control_clk_i;
    int cyc = 0;
    always @(posedge control_clk_i) cyc <= cyc + 1;

    sd_spi_master dut (
        .control_clk_i(control_clk_i), .control_rst_i(control_rst_i), .spi_rst_i(spi_rst_i),
        .spi_start_i(spi_start_i), .spi_fbo_i(spi_fbo_i), .instruction_i(instruction_i),
        .clock_divider_i(clock_divider_i), .resp_len_i(resp_len_i), .spi_data_o(spi_data_o),
        .spi_done_o(spi_done_o), .spi_busy_o(spi_busy_o), .spi_timeout_o(spi_timeout_o),
        .sd_sck_o(sd_sck_o), .sd_mosi_o(sd_mosi_o), .sd_cs_n_o(sd_cs_n_o), .sd_miso_i(sd_miso_i)
    );

    typedef struct {
        logic        fill;
        logic [47:0] data;
        logic        to;
        logic [47:0] frame;
        int          fill_base;
        int          t_start;
        logic        chk_lat;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    logic [47:0] last_data = '0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Card: after the 48 command clocks it presents its byte stream, MSB first, idling at 1.
    logic [7:0] card_bytes [16];
    int card_n = 0;
    int fall_cnt = 0;

    function automatic logic [7:0] card_byte(input int k);
        if (k >= card_n) return 8'hFF;
        return card_bytes[k];
    endfunction

    always @(negedge sd_sck_o or posedge sd_cs_n_o) begin
        if (sd_cs_n_o) begin
            fall_cnt  = 0;
            sd_miso_i = 1'b1;
        end else begin
            logic [7:0] b;
            fall_cnt++;
            if (fall_cnt >= 48) begin
                b = card_byte((fall_cnt - 48) / 8);
                sd_miso_i = b[7 - ((fall_cnt - 48) % 8)];
            end
        end
    end

    logic [47:0] frame_cap = '0;
    int rise_cnt = 0, fill_rises = 0;
    logic fill_bad = 1'b0;
    always @(posedge sd_sck_o or negedge sd_cs_n_o) begin
        if (sd_sck_o === 1'b1) begin
            if (!sd_cs_n_o) begin
                if (rise_cnt < 48) frame_cap = {frame_cap[46:0], sd_mosi_o};
                rise_cnt++;
            end else begin
                fill_rises++;
                if (sd_mosi_o !== 1'b1) fill_bad = 1'b1;
            end
        end else begin
            rise_cnt = 0;
        end
    end

    logic prev_done = 1'b0;
    always @(negedge control_clk_i) begin
        if (spi_done_o) begin
            check("done_single_cycle", 48'(prev_done), 48'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 48'(sb.size()), 48'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data", spi_data_o, e.data);
                check("timeout", 48'(spi_timeout_o), 48'(e.to));
                if (e.fill) begin
                    check("fill_sck_rises", 48'(fill_rises - e.fill_base), 48'd80);
                    check("fill_mosi_high", 48'(fill_bad), 48'd0);
                end else begin
                    check("mosi_frame", frame_cap, e.frame);
                end
                if (e.chk_lat) check("latency_r1", 48'(cyc - e.t_start + 1), 48'(LAT_R1));
            end
        end
        prev_done = spi_done_o;
    end

    // Frame on the wire: verbatim, or with CRC7 by polynomial long division.
    function automatic logic [47:0] model_frame(input logic [47:0] ins);
        logic [47:0] f = ins;
`ifdef SD_SPI_CRC7_EN
        logic [46:0] r = {ins[47:8], 7'b0};
        for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
        f[7:0] = {r[6:0], 1'b1};
`endif
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge control_clk_i);
        #1;
    endtask

    task automatic set_card(input logic [63:0] v, input int n);
        for (int k = 0; k < 8; k++) card_bytes[k] = v[63 - 8 * k -: 8];
        card_n = n;
    endtask

    task automatic issue(input logic fbo, input logic [47:0] ins, input logic [1:0] div,
                         input logic [2:0] len, input logic lat);
        exp_t e;
        int tok, L;
        logic [7:0] b;
        e.fill = fbo; e.frame = model_frame(ins); e.fill_base = fill_rises;
        e.t_start = cyc; e.chk_lat = lat; e.to = 1'b0; e.data = last_data;
        if (!fbo) begin
            L = (len == 3'd0) ? 1 : (len == 3'd7) ? 6 : int'(len);
            tok = -1;
            for (int k = 0; k < NCR; k++) begin
                b = card_byte(k);
                if (tok < 0 && !b[7]) tok = k;
            end
            if (tok < 0) begin
                e.data = '1;
                e.to   = 1'b1;
            end else begin
                e.data = '0;
                for (int j = 0; j < L; j++) e.data = {e.data[39:0], card_byte(tok + j)};
            end
            last_data = e.data;
        end
        sb.push_back(e);
        spi_fbo_i = fbo; instruction_i = ins; clock_divider_i = div; resp_len_i = len;
        spi_start_i = 1'b1;
        tick(1);
        spi_start_i = 1'b0; spi_fbo_i = 1'b0;
        instruction_i = {16'($urandom), $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((spi_busy_o || sb.size() != 0) && n < 40000) begin
            tick(1);
            n++;
        end
        check("idle_wait_expired", 48'(n >= 40000), 48'd0);
        tick(2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        int tokpos;
        tick(3);
        control_rst_i = 1'b0;
        tick(2);
        check("rst_sck", 48'(sd_sck_o), 48'd0);
        check("rst_mosi", 48'(sd_mosi_o), 48'd1);
        check("rst_cs_n", 48'(sd_cs_n_o), 48'd1);
        check("rst_busy", 48'(spi_busy_o), 48'd0);
        check("rst_done", 48'(spi_done_o), 48'd0);
        check("rst_timeout", 48'(spi_timeout_o), 48'd0);
        check("rst_data", spi_data_o, 48'd0);

        issue(1'b1, 48'd0, 2'd3, 3'd1, 1'b0); wait_idle();
        set_card(64'h0100_0000_0000_0000, 1);
        issue(1'b0, 48'h400000000095, 2'd3, 3'd1, 1'b1); wait_idle();
        set_card(64'hFF01_0000_0000_0000, 2);
        issue(1'b0, 48'h400000000095, 2'd3, 3'd1, 1'b0); wait_idle();
        set_card(64'hFFFF_0100_0001_AA00, 7);
        issue(1'b0, 48'h48000001AA87, 2'd3, 3'd5, 1'b0); wait_idle();
        set_card(64'd0, 0);
        issue(1'b0, 48'h7A0000000001, 2'd3, 3'd1, 1'b0); wait_idle();
        issue(1'b1, 48'd0, 2'd2, 3'd1, 1'b0); wait_idle();
        set_card(64'h0100_0000_0000_0000, 1);
        issue(1'b0, 48'h400000000000, 2'd2, 3'd1, 1'b0); wait_idle();

        // Slowest divider: measure a high phase, then try a start while busy.
        issue(1'b0, 48'h400000000095, 2'd0, 3'd1, 1'b0);
        n = 0;
        while (sd_sck_o !== 1'b1 && n < 2000) begin @(negedge control_clk_i); n++; end
        n = 0;
        while (sd_sck_o === 1'b1 && n < 1000) begin @(negedge control_clk_i); n++; end
        check("sck_half_div0", 48'(n), 48'd128);
        tick(1);
        instruction_i = 48'hFFFF_FFFF_FFFF; spi_fbo_i = 1'b1; spi_start_i = 1'b1;
        tick(1);
        spi_start_i = 1'b0; spi_fbo_i = 1'b0;
        wait_idle();

        // Abort mid-command: idle next cycle, no done afterwards.
        instruction_i = 48'h51_0000_0000_FF; clock_divider_i = 2'd2; spi_start_i = 1'b1;
        tick(1);
        spi_start_i = 1'b0;
        tick(40);
        spi_rst_i = 1'b1;
        tick(1);
        spi_rst_i = 1'b0;
        check("abort_busy", 48'(spi_busy_o), 48'd0);
        check("abort_cs_n", 48'(sd_cs_n_o), 48'd1);
        check("abort_sck", 48'(sd_sck_o), 48'd0);
        check("abort_mosi", 48'(sd_mosi_o), 48'd1);
        check("abort_data", spi_data_o, 48'd0);
        last_data = '0;
        tick(600);

        repeat (12) begin
            tokpos = $urandom_range(0, 9);
            for (int k = 0; k < 16; k++) begin
                b = 8'($urandom);
                if (k < tokpos) b[7] = 1'b1;
                else if (k == tokpos) b[7] = 1'b0;
                card_bytes[k] = b;
            end
            card_n = 16;
            issue(($urandom_range(0, 5) == 0), {16'($urandom), $urandom},
                  2'($urandom_range(2, 3)), 3'($urandom_range(0, 7)), 1'b0);
            wait_idle();
        end

        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
